// File: rtl/spgd_update_engine_if.sv
// Handshake and data bundle between the SPGD update engine and its controller.
// master drives the commands and operands; slave is the engine side.
interface spgd_update_engine_if #(
    parameter int unsigned AdcWidth  = 12,
    parameter int unsigned DacWidth  = 14,
    parameter int unsigned GainWidth = 12,
    parameter int unsigned NumCh     = 4
);
    logic                      start;
    logic [AdcWidth-1:0]       j_p;
    logic [AdcWidth-1:0]       j_m;
    logic [GainWidth-1:0]      gain;
    logic [NumCh*DacWidth-1:0] delta_u;
    logic                      load;
    logic [NumCh*DacWidth-1:0] load_u;
    logic [NumCh*DacWidth-1:0] u_out;
    logic                      busy;
    logic                      done;
    logic [NumCh-1:0]          sat;

    modport master (
        output start, j_p, j_m, gain, delta_u, load, load_u,
        input  u_out, busy, done, sat
    );

    modport slave (
        input  start, j_p, j_m, gain, delta_u, load, load_u,
        output u_out, busy, done, sat
    );
endinterface

// File: rtl/spgd_update_engine.sv
// Multi-channel SPGD control law: U[k] <= sat(U[k] + ((J+ - J-) * gain * delta_u[k]) >>> Shift),
// one channel per clock through a single shared multiplier.
module spgd_update_engine #(
    parameter int unsigned AdcWidth  = 12,
    parameter int unsigned DacWidth  = 14,
    parameter int unsigned GainWidth = 12,
    parameter int unsigned NumCh     = 4,
    parameter int unsigned Shift     = 8,
    parameter int unsigned UInit     = 8192
) (
    input logic                 clk,
    input logic                 rst,
    spgd_update_engine_if.slave eng_io
);

    localparam int unsigned GWidth = AdcWidth + GainWidth + 1;
    localparam int unsigned PWidth = GWidth + DacWidth;
    localparam int unsigned SWidth = PWidth + 1;
    localparam int unsigned ChW    = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam logic [DacWidth-1:0] UMax = '1;

    typedef enum logic [1:0] {StIdle, StGain, StUpd} state_e;

    state_e                    state_q, state_d;
    logic [ChW-1:0]            ch_q, ch_d;
    logic signed [AdcWidth:0]  dj_q, dj_d;
    logic [GainWidth-1:0]      gain_q, gain_d;
    logic [NumCh*DacWidth-1:0] delta_q, delta_d;
    logic signed [GWidth-1:0]  g_q, g_d;
    logic [DacWidth-1:0]       u_q [NumCh];
    logic [DacWidth-1:0]       u_d [NumCh];
    logic [NumCh-1:0]          sat_q, sat_d;
    logic                      done_q, done_d;

    logic signed [DacWidth-1:0] delta_ch;
    logic [DacWidth-1:0]        u_cur;
    logic signed [PWidth-1:0]   prod;
    logic signed [PWidth-1:0]   term;
    logic signed [SWidth-1:0]   sum;
    logic [DacWidth-1:0]        u_new;
    logic                       sat_new;

    // Per-channel datapath: full-width product, floor shift, then clamp to the DAC range.
    always_comb begin
        delta_ch = delta_q[int'(ch_q)*DacWidth +: DacWidth];
        u_cur    = u_q[ch_q];
        prod     = g_q * delta_ch;
        term     = prod >>> Shift;
        sum      = SWidth'(term) + $signed(SWidth'({1'b0, u_cur}));
        u_new    = sum[DacWidth-1:0];
        sat_new  = 1'b0;
        if (sum < 0) begin
            u_new   = '0;
            sat_new = 1'b1;
        end else if (sum > $signed(SWidth'(UMax))) begin
            u_new   = UMax;
            sat_new = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        dj_d    = dj_q;
        gain_d  = gain_q;
        delta_d = delta_q;
        g_d     = g_q;
        u_d     = u_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (eng_io.load) begin
                    for (int k = 0; k < NumCh; k++) begin
                        u_d[k] = eng_io.load_u[k*DacWidth +: DacWidth];
                    end
                    sat_d = '0;
                end else if (eng_io.start) begin
                    dj_d    = $signed({1'b0, eng_io.j_p}) - $signed({1'b0, eng_io.j_m});
                    gain_d  = eng_io.gain;
                    delta_d = eng_io.delta_u;
                    state_d = StGain;
                end
            end
            StGain: begin
                g_d     = dj_q * $signed({1'b0, gain_q});
                ch_d    = '0;
                state_d = StUpd;
            end
            StUpd: begin
                u_d[ch_q]   = u_new;
                sat_d[ch_q] = sat_new;
                if (ch_q == ChW'(NumCh - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    ch_d = ch_q + ChW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ch_q    <= '0;
            dj_q    <= '0;
            gain_q  <= '0;
            delta_q <= '0;
            g_q     <= '0;
            sat_q   <= '0;
            done_q  <= 1'b0;
            for (int k = 0; k < NumCh; k++) begin
                u_q[k] <= DacWidth'(UInit);
            end
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dj_q    <= dj_d;
            gain_q  <= gain_d;
            delta_q <= delta_d;
            g_q     <= g_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
            for (int k = 0; k < NumCh; k++) begin
                u_q[k] <= u_d[k];
            end
        end
    end

    assign eng_io.busy = (state_q != StIdle);
    assign eng_io.done = done_q;
    assign eng_io.sat  = sat_q;

    for (genvar k = 0; k < NumCh; k++) begin : g_uout
        assign eng_io.u_out[k*DacWidth +: DacWidth] = u_q[k];
    end

endmodule

// File: tb/tb_spgd_update_engine.sv
// Scoreboard bench for spgd_update_engine: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever done pulses.
module tb_spgd_update_engine;

    localparam int unsigned DW = 14;
    localparam int unsigned NC = 4;

    typedef struct packed {
        logic [NC*DW-1:0] u;
        logic [NC-1:0]    sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    spgd_update_engine_if #(
        .AdcWidth(12), .DacWidth(DW), .GainWidth(12), .NumCh(NC)
    ) bus ();

    spgd_update_engine #(
        .AdcWidth(12), .DacWidth(DW), .GainWidth(12), .NumCh(NC), .Shift(8), .UInit(8192)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .eng_io(bus)
    );

    function automatic logic [NC*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending sequence");
            end else begin
                e = sb.pop_front();
                check("done_u_out", 64'(bus.u_out), 64'(e.u));
                check("done_sat", 64'(bus.sat), 64'(e.sat));
            end
        end
    end

    task automatic do_load(input int v);
        bus.load   = 1'b1;
        bus.load_u = pack4(v, v, v, v);
        @(negedge clk);
        bus.load   = 1'b0;
    endtask

    // Drives start for one edge at the current negedge and records the expected outcome.
    task automatic issue_start(input int jp, input int jm, input int g, input logic [NC*DW-1:0] du,
                               input logic [NC*DW-1:0] eu, input logic [NC-1:0] es, input bit push);
        exp_t x;
        bus.start   = 1'b1;
        bus.j_p     = 12'(jp);
        bus.j_m     = 12'(jm);
        bus.gain    = 12'(g);
        bus.delta_u = du;
        x.u   = eu;
        x.sat = es;
        if (push) sb.push_back(x);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int first, input int exp_busy);
        int cyc  = first;
        int nb   = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.busy) nb++;
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout: got no done within 20 cycles expected done");
        end else begin
            check("done_latency", 64'(cyc), 64'(6));
            check("busy_cycles", 64'(nb), 64'(exp_busy));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC*DW-1:0] d16, tbl[7];
        bit seen;
        d16 = pack4(16, 16, 16, 16);
        rst = 1'b1;
        bus.start = 1'b0; bus.load = 1'b0; bus.j_p = '0; bus.j_m = '0; bus.gain = '0;
        bus.delta_u = '0; bus.load_u = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_u_out", 64'(bus.u_out), 64'(pack4(8192, 8192, 8192, 8192)));
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        check("reset_sat", 64'(bus.sat), 64'(0));

        // dJ=64, G=256, P=4096, term=+16
        issue_start(100, 36, 4, d16, pack4(8208, 8208, 8208, 8208), 4'h0, 1'b1);
        wait_done(1, 5);

        do_load(8192);
        issue_start(36, 100, 4, d16, pack4(8176, 8176, 8176, 8176), 4'h0, 1'b1);
        wait_done(1, 5);

        // -1 >>> 8 floors to -1
        do_load(8192);
        issue_start(0, 1, 1, pack4(1, 1, 1, 1), pack4(8191, 8191, 8191, 8191), 4'h0, 1'b1);
        wait_done(1, 5);

        do_load(16380);
        issue_start(4095, 0, 4095, pack4(8191, 8191, 8191, 8191),
                    pack4(16383, 16383, 16383, 16383), 4'hf, 1'b1);
        wait_done(1, 5);

        do_load(5);
        issue_start(4095, 0, 4095, pack4(-8192, -8192, -8192, -8192), pack4(0, 0, 0, 0), 4'hf, 1'b1);
        wait_done(1, 5);
        repeat (3) @(negedge clk);
        check("sat_holds", 64'(bus.sat), 64'(4'hf));

        // Per-channel deltas, watching channels land one per cycle in order
        do_load(8192);
        check("load_clears_sat", 64'(bus.sat), 64'(0));
        tbl[1] = pack4(8192, 8192, 8192, 8192);
        tbl[2] = pack4(8192, 8192, 8192, 8192);
        tbl[3] = pack4(8208, 8192, 8192, 8192);
        tbl[4] = pack4(8208, 8176, 8192, 8192);
        tbl[5] = pack4(8208, 8176, 8192, 8192);
        tbl[6] = pack4(8208, 8176, 8192, 8224);
        issue_start(100, 36, 4, pack4(16, -16, 0, 32), tbl[6], 4'h0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            check($sformatf("order_cycle%0d", c), 64'(bus.u_out), 64'(tbl[c]));
            if (c < 6) @(negedge clk);
        end
        @(negedge clk);

        // start at T+2 and load at T+3 are ignored
        do_load(8192);
        issue_start(100, 36, 4, d16, pack4(8208, 8208, 8208, 8208), 4'h0, 1'b1);
        @(negedge clk);
        bus.start = 1'b1; bus.j_p = 12'd4095; bus.gain = 12'd4095;
        @(negedge clk);
        bus.start = 1'b0; bus.load = 1'b1; bus.load_u = pack4(100, 100, 100, 100);
        @(negedge clk);
        bus.load = 1'b0;
        wait_done(4, 2);
        repeat (8) @(negedge clk);
        check("ignored_u_out", 64'(bus.u_out), 64'(pack4(8208, 8208, 8208, 8208)));
        check("ignored_busy", 64'(bus.busy), 64'(0));

        // load wins over simultaneous start
        bus.load = 1'b1; bus.load_u = pack4(1000, 1000, 1000, 1000);
        bus.start = 1'b1; bus.j_p = 12'd100; bus.j_m = 12'd36; bus.gain = 12'd4; bus.delta_u = d16;
        @(negedge clk);
        bus.load = 1'b0; bus.start = 1'b0;
        check("load_start_busy", 64'(bus.busy), 64'(0));
        repeat (8) @(negedge clk);
        check("load_start_u_out", 64'(bus.u_out), 64'(pack4(1000, 1000, 1000, 1000)));

        // start in the done cycle is accepted back to back
        do_load(8192);
        issue_start(100, 36, 4, d16, pack4(8208, 8208, 8208, 8208), 4'h0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("first_done_seen", 64'(seen), 64'(1));
        issue_start(100, 36, 4, d16, pack4(8224, 8224, 8224, 8224), 4'h0, 1'b1);
        wait_done(1, 5);

        // Reset in the middle of the update sequence
        do_load(8192);
        issue_start(100, 36, 4, d16, '0, 4'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("partial_ch0_written", 64'(bus.u_out), 64'(pack4(8208, 8192, 8192, 8192)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_u_out", 64'(bus.u_out), 64'(pack4(8192, 8192, 8192, 8192)));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_sat", 64'(bus.sat), 64'(0));
        repeat (8) @(negedge clk);
        check("midrst_no_done", 64'(bus.u_out), 64'(pack4(8192, 8192, 8192, 8192)));

        check("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
